// File: rtl/shift_sequencer_pkg.sv
// shift_sequencer_pkg: shared op codes, FSM state encoding and default counter width
package shift_sequencer_pkg;
  localparam int CNT_W_DEF = 4;
  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_LSL  = 2'b01;
  localparam logic [1:0] OP_LSR  = 2'b10;
  localparam logic [1:0] OP_ASR  = 2'b11;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
endpackage

// File: rtl/shift_sequencer_shifter.sv
// p3_shifter: 16-bit single-step shifter (in: operand, shift: op code, sout: result)
module p3_shifter
  import shift_sequencer_pkg::*;
(
  input  logic [15:0] in,
  input  logic [1:0]  shift,
  output logic [15:0] sout
);
  always_comb
    sout = shift == OP_LSL ? {in[14:0], 1'b0} :
           shift == OP_LSR ? {1'b0, in[15:1]} :
           shift == OP_ASR ? {in[15], in[15:1]} : in;
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle 16-bit shifter; start/op/amount/din in, busy/done/dout out
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] amount,
  input  logic [15:0]      din,
  output logic             busy,
  output logic             done,
  output logic [15:0]      dout
);
  logic [1:0]       state_q, state_d, op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      acc_q, acc_d, sh_out;
  logic             load;
  always_comb begin
    load    = state_q == ST_IDLE && start;
    op_d    = load ? op : op_q;
    cnt_d   = load ? amount : state_q == ST_SHIFT ? cnt_q - CNT_W'(1) : cnt_q;
    state_d = load ? (amount != '0 && op != OP_PASS ? ST_SHIFT : ST_DONE) :
              state_q == ST_SHIFT ? (cnt_q == CNT_W'(1) ? ST_DONE : ST_SHIFT) :
              state_q == ST_DONE ? ST_IDLE : state_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_PASS;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  p3_shifter u_shifter (.in(acc_q), .shift(op_q), .sout(sh_out));
  always_comb acc_d = load ? din : state_q == ST_SHIFT ? sh_out : acc_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) acc_q <= '0;
    else acc_q <= acc_d;
  assign busy = state_q != ST_IDLE;
  assign done = state_q == ST_DONE;
  assign dout = acc_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: table-driven, hand-sequenced and randomized checks of shift_sequencer
module tb_shift_sequencer;
  logic        clk = 0, reset_n = 0, start = 0;
  logic [1:0]  op_s = 0;
  logic [3:0]  amt_s = 0;
  logic [15:0] din_s = 0;
  logic        busy, done;
  logic [15:0] dout;
  int          n_pass = 0, n_total = 0;

  shift_sequencer #(.CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op_s), .amount(amt_s),
    .din(din_s), .busy(busy), .done(done), .dout(dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  amt;
    logic [15:0] din;
    logic [15:0] exp;
    int          lat;
  } vec_t;
  vec_t tbl[9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  function automatic logic [15:0] ref_shift(input logic [1:0] o, input int n, input logic [15:0] d);
    logic [15:0] r;
    case (o)
      2'd1: r = d << n;
      2'd2: r = d >> n;
      2'd3: r = 16'($signed(d) >>> n);
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input int n);
    return (o == 2'd0 || n == 0) ? 1 : n + 1;
  endfunction

  // Called at a negedge in IDLE; returns at the negedge of the first IDLE cycle after DONE.
  task automatic run(input logic [1:0] o, input logic [3:0] a, input logic [15:0] d,
                     input logic [15:0] e, input int el, input string nm);
    int  lat = 0;
    bit  bz = 1, fin = 0;
    op_s = o; amt_s = a; din_s = d; start = 1;
    @(posedge clk);
    #1 start = 0; din_s = 16'($urandom); op_s = 2'($urandom); amt_s = 4'($urandom);
    for (int i = 0; i < 40 && !fin; i++) begin
      @(negedge clk);
      lat++;
      if (!busy) bz = 0;
      if (done) fin = 1;
    end
    check({nm, " latency"}, lat, el);
    check({nm, " busy"}, bz, 1);
    check({nm, " dout"}, dout, e);
    @(negedge clk);
    check({nm, " idle busy/done"}, {busy, done}, 2'b00);
    check({nm, " dout hold"}, dout, e);
  endtask

  initial begin
    tbl[0] = '{2'd1, 4'd4,  16'h0001, 16'h0010, 5};
    tbl[1] = '{2'd3, 4'd3,  16'h8000, 16'hF000, 4};
    tbl[2] = '{2'd2, 4'd15, 16'h8000, 16'h0001, 16};
    tbl[3] = '{2'd1, 4'd0,  16'hA5A5, 16'hA5A5, 1};
    tbl[4] = '{2'd0, 4'd9,  16'hA5A5, 16'hA5A5, 1};
    tbl[5] = '{2'd3, 4'd15, 16'h8000, 16'hFFFF, 16};
    tbl[6] = '{2'd1, 4'd15, 16'hFFFF, 16'h8000, 16};
    tbl[7] = '{2'd2, 4'd1,  16'h8001, 16'h4000, 2};
    tbl[8] = '{2'd3, 4'd3,  16'h7FFF, 16'h0FFF, 4};
    start = 1;
    repeat (3) @(negedge clk);
    check("reset outputs", {busy, done, dout}, 18'h0);
    start = 0;
    reset_n = 1;
    @(negedge clk);
    check("post-reset idle", {busy, done, dout}, 18'h0);
    foreach (tbl[i]) run(tbl[i].op, tbl[i].amt, tbl[i].din, tbl[i].exp, tbl[i].lat, $sformatf("vec%0d", i));
    begin
      int lat = 0, ndone = 0, dlat = 0;
      op_s = 2'd1; amt_s = 4'd6; din_s = 16'h0003; start = 1;
      @(posedge clk);
      #1 op_s = 2'd2; amt_s = 4'd1; din_s = 16'hFFFF;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        lat++;
        if (done) begin
          ndone++;
          if (ndone == 1) dlat = lat;
        end else if (ndone != 0) start = 0;
      end
      check("held start done count", ndone, 1);
      check("held start latency", dlat, 7);
      check("held start dout", dout, 16'h00C0);
      check("held start idle", {busy, done}, 2'b00);
    end
    op_s = 2'd1; amt_s = 4'd8; din_s = 16'h0001; start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (3) @(negedge clk);
    check("mid-shift dout", dout, 16'h0004);
    check("mid-shift busy", busy, 1);
    reset_n = 0;
    #1 check("async reset outputs", {busy, done, dout}, 18'h0);
    @(negedge clk);
    check("held reset outputs", {busy, done, dout}, 18'h0);
    reset_n = 1;
    @(negedge clk);
    run(2'd2, 4'd2, 16'h00F0, 16'h003C, 3, "after reset");
    for (int i = 0; i < 30; i++) begin
      logic [1:0]  o;
      logic [3:0]  a;
      logic [15:0] d;
      o = 2'($urandom_range(0, 3));
      a = 4'($urandom_range(0, 15));
      d = 16'($urandom);
      run(o, a, d, ref_shift(o, int'(a), d), ref_lat(o, int'(a)), $sformatf("rand%0d", i));
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter: CNT_W, default 4, width of shift-amount input and internal step counter (max amount 2^CNT_W-1).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request pulse; sampled on rising edge of clk only in IDLE.
REQ-005 op  input  2  shift code: 00 pass, 01 logical left, 10 logical right, 11 arithmetic right.
REQ-006 amount  input  CNT_W  number of 1-bit steps to apply.
REQ-007 din  input  16  operand.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 done  output  1  single-cycle completion pulse.
REQ-010 dout  output  16  result register; valid from done cycle until next accepted start.

Function
REQ-011 FSM states IDLE, SHIFT, DONE; encoding from shared package.
REQ-012 IDLE + start=1 at edge k: latch din into acc, op into op_r, amount into cnt; next state SHIFT if amount!=0 and op!=00, else DONE.
REQ-013 start in SHIFT or DONE: ignored, no effect on acc, cnt, op_r or state.
REQ-014 SHIFT: each edge acc <= one-step shift of acc by op_r, cnt <= cnt-1; when cnt==1 at edge, next state DONE.
REQ-015 Latency: amount N>=1 with op!=00 -> shifts at edges k+1..k+N, done=1 in cycle after edge k+N, IDLE after edge k+N+1; N=0 or op=00 -> done=1 in cycle after edge k, dout=din.
REQ-016 DONE: done=1, busy=1, next state IDLE unconditionally; a start arriving in DONE is dropped.
REQ-017 dout driven directly from acc; holds value through IDLE until next accepted start reloads acc.
REQ-018 Step semantics: LSL shifts in 0 at bit0; LSR shifts in 0 at bit15; ASR replicates bit15; all results 16-bit, shifted-out bits discarded.
REQ-019 Maximum amount (15 for CNT_W=4) fully supported; counter never wraps (decrement stops at transition to DONE).
REQ-020 done and busy are registered-state decodes, glitch-free, no combinational path from start.

Reset
REQ-021 reset_n=0 at any time, including mid-SHIFT or DONE: state=IDLE, acc=0, cnt=0, op_r=00 immediately (asynchronous).
REQ-022 Outputs during/after reset: busy=0, done=0, dout=0x0000.
REQ-023 First start accepted on first rising edge with reset_n=1 and start=1.

Structure
REQ-024 Shared package/include holds: op codes (PASS, LSL, LSR, ASR), FSM state encoding, default CNT_W.
REQ-025 One sub-module: the team's existing 16-bit single-step shifter (p3_shifter; in, shift, sout), instantiated once, fed acc and op_r, output registered into acc.
REQ-026 Control (FSM, counter) and datapath (acc register plus shifter) kept separate in the RTL.

Verification
REQ-027 start, op=01, amount=4, din=0x0001 -> done 1 cycle after 4th shift edge, dout=0x0010, busy high 5 cycles.
REQ-028 op=11, amount=3, din=0x8000 -> dout=0xF000; op=10, amount=15, din=0x8000 -> dout=0x0001.
REQ-029 op=01, amount=0, din=0xA5A5 -> done in cycle after start edge, dout=0xA5A5; same for op=00, amount=9.
REQ-030 start re-asserted every cycle during a 6-step shift, including in DONE -> only first request processed, one done pulse, result unchanged.
REQ-031 reset_n pulsed low mid-SHIFT (after 2 of 8 steps) -> busy=0, done=0, dout=0x0000 immediately; subsequent start runs cleanly.
REQ-032 Back-to-back: start asserted first cycle after DONE (in IDLE) -> accepted, no lost or duplicated done pulse.
